dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_pkg.sv | 17 +
 rtl/dmem_ctrl.sv | 129 ++++++++++++
 tb/tb_dmem_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller.
// Holds the MEM-stage request codes, bus widths and zero constants that
// dmem_ctrl and its users agree on. State encodings stay local to dmem_ctrl.
package dmem_ctrl_pkg;

  localparam int MEMRW_W = 2;   // memrw bus width
  localparam int DATA_W  = 32;  // data bus width
  localparam int ADDR_W  = 32;  // byte address bus width

  localparam logic [MEMRW_W-1:0] MEMRW_IDLE  = 2'b00;
  localparam logic [MEMRW_W-1:0] MEMRW_READ  = 2'b01;
  localparam logic [MEMRW_W-1:0] MEMRW_WRITE = 2'b10;

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: turns a single-word MEM-stage read/write into a multi-cycle
// asynchronous-SRAM bus cycle, stalling the pipeline while it is in flight.
//
// Optional feature: define DMEM_ALIGN_CHK_EN to add the addr_err port. A
// misaligned request (memaddr[1:0] != 0) then skips the SRAM and completes
// in one stall cycle with addr_err high in its DONE cycle.
//
// Ports:
//   gclk, grst_n      clock; synchronous active-low reset
//   memrw             00 idle, 01 read, 10 write, 11 treated as idle
//   memaddr, memdata  byte address and write data (latched in IDLE)
//   rdata             last completed read, valid in DONE
//   stall_req         pipeline freeze request (combinational)
//   addr_err          misaligned flag (DMEM_ALIGN_CHK_EN only)
//   sram_*            async SRAM pad signals; strobes active-low, registered
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               gclk,
  input  logic               grst_n,
  input  logic [MEMRW_W-1:0] memrw,
  input  logic [ADDR_W-1:0]  memaddr,
  input  logic [DATA_W-1:0]  memdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               stall_req,
`ifdef DMEM_ALIGN_CHK_EN
  output logic               addr_err,
`endif
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_dq_o,
  input  logic [DATA_W-1:0]  sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_rd, req_wr, req, misaligned;
  logic             unused_addr_bits;

  assign req_rd = (memrw == MEMRW_READ);
  assign req_wr = (memrw == MEMRW_WRITE);
  assign req    = req_rd | req_wr;

`ifdef DMEM_ALIGN_CHK_EN
  assign misaligned = (memaddr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Byte offset and bits above the SRAM word range never reach the bus.
  assign unused_addr_bits = ^{memaddr[ADDR_W-1:SRAM_AW+2], memaddr[1:0]};

  // Gated by reset so a request held during reset does not freeze the pipe.
  assign stall_req = grst_n & req & (state != S_DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (misaligned)  nxt = S_DONE;
          else if (req_rd) nxt = S_RD_WAIT;
          else             nxt = S_WR_SETUP;
        end
      end
      S_RD_WAIT:  if (cnt == '0) nxt = S_DONE;
      S_WR_SETUP: nxt = S_WR_PULSE;
      S_WR_PULSE: if (cnt == '0) nxt = S_WR_HOLD;
      S_WR_HOLD:  nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rdata      <= ZERO_DATA;
      sram_addr  <= ZERO_ADDR[SRAM_AW-1:0];
      sram_dq_o  <= ZERO_DATA;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
`ifdef DMEM_ALIGN_CHK_EN
      addr_err   <= 1'b0;
`endif
    end else begin
      state <= nxt;

      // Reload on every state change; only the wait states consume it.
      if (nxt != state)    cnt <= CNT_LOAD;
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      // Latched copies make the bus immune to mid-access input changes.
      if (state == S_IDLE && req) begin
        sram_addr <= memaddr[SRAM_AW+1:2];
        sram_dq_o <= memdata;
      end

      if (state == S_RD_WAIT && nxt == S_DONE) rdata <= sram_dq_i;

      // Strobes come from the next state so they leave a flop glitch-free.
      sram_ce_n  <= !(nxt inside {S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
      sram_oe_n  <= (nxt != S_RD_WAIT);
      sram_we_n  <= (nxt != S_WR_PULSE);
      sram_dq_oe <= (nxt inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
`ifdef DMEM_ALIGN_CHK_EN
      // IDLE -> DONE is taken only by a misaligned request.
      addr_err   <= (state == S_IDLE) && (nxt == S_DONE);
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: async SRAM model, word-level reference
// memory, directed steps plus a randomized request stream.
module tb_dmem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  memrw;
  logic [31:0] memaddr, memdata;
  logic [31:0] rdata;
  logic        stall_req;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef DMEM_ALIGN_CHK_EN
  logic        addr_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(20)) dut (
    .gclk       (clk),
    .grst_n     (rst_n),
    .memrw      (memrw),
    .memaddr    (memaddr),
    .memdata    (memdata),
    .rdata      (rdata),
    .stall_req  (stall_req),
`ifdef DMEM_ALIGN_CHK_EN
    .addr_err   (addr_err),
`endif
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  // ---------------- async SRAM model (1K words) ----------------
  function automatic logic [31:0] init_pat(input int w);
    return 32'(w) * 32'h9E37_79B9 ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] sram_mem [0:1023];
  bit          sram_wr  [0:1023];

  // Write commits on the rising edge of we_n while the chip is selected.
  always @(posedge sram_we_n)
    if (sram_ce_n === 1'b0) begin
      sram_mem[sram_addr[9:0]] <= sram_dq_o;
      sram_wr[sram_addr[9:0]]  <= 1'b1;
    end

  assign sram_dq_i = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0)
                   ? (sram_wr[sram_addr[9:0]] ? sram_mem[sram_addr[9:0]]
                                              : init_pat(int'(sram_addr[9:0])))
                   : 32'hBAD0_BAD0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;

  function automatic logic [31:0] ref_read(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request from its first IDLE cycle through DONE; returns DONE's cycle.
  task automatic do_req(input logic [1:0] rw, input logic [31:0] a,
                        input logic [31:0] d, input bit disturb,
                        output int done_cyc);
    int n, stalls, wes;
    bit done, overlap, addr_bad, is_rd, is_wr, mis;
    logic [31:0] exp_rd;
    is_rd = (rw == 2'b01);
    is_wr = (rw == 2'b10);
    mis   = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
    mis = (a[1:0] != 2'b00) && (is_rd || is_wr);
`endif
    @(posedge clk); #1;
    memrw = rw; memaddr = a; memdata = d;
    n = 0; stalls = 0; wes = 0; done = 0; overlap = 0; addr_bad = 0;
    done_cyc = 0;
    while (!done && n < 40) begin
      @(negedge clk); n++;
      if (sram_we_n === 1'b0) wes++;
      if (sram_we_n === 1'b0 && sram_oe_n === 1'b0) overlap = 1;
      if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) overlap = 1;
      if (sram_ce_n === 1'b0 && sram_addr !== a[21:2]) addr_bad = 1;
      if (stall_req === 1'b1) stalls++;
      else begin done = 1; done_cyc = cyc; end
      if (disturb && n == 2) begin
        memaddr = 32'h0000_03FC; memdata = $urandom;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    if (!done) begin memrw = 2'b00; return; end
    if (mis)        chk("stall_cycles", stalls, 1);
    else if (is_rd) chk("stall_cycles", stalls, W + 1);
    else if (is_wr) chk("stall_cycles", stalls, W + 3);
    else            chk("stall_cycles", stalls, 0);
    chk("we_cycles", wes, (is_wr && !mis) ? W : 0);
    chk("strobe_overlap", 32'(overlap), 32'd0);
    chk("addr_held", 32'(addr_bad), 32'd0);
    chk("done_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
    exp_rd = (is_rd && !mis) ? ref_read(int'(a[11:2])) : last_rd;
    chk("rdata", rdata, exp_rd);
`ifdef DMEM_ALIGN_CHK_EN
    chk("addr_err", 32'(addr_err), 32'(mis));
`endif
    if (is_wr && !mis) ref_mem[int'(a[11:2])] = d;
    last_rd = exp_rd;
    memrw = 2'b00;
  endtask

  initial begin
    int c1, c2, k;
    bit found;
    rst_n = 1'b0; memrw = 2'b01; memaddr = 32'h10; memdata = 32'h0;

    // reset with a read request pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
    chk("rst_addr", {12'h0, sram_addr}, 32'h0);
    chk("rst_dq_o", sram_dq_o, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
    chk("rst_addr_err", 32'(addr_err), 32'd0);
`endif

    // idle: no strobe activity
    @(posedge clk); #1; rst_n = 1'b1; memrw = 2'b00;
    found = 0;
    repeat (3) begin
      @(negedge clk);
      if (sram_ce_n !== 1'b1 || stall_req !== 1'b0) found = 1;
    end
    chk("idle_quiet", 32'(found), 32'd0);

    // write then read
    do_req(2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 0, c1);
    do_req(2'b01, 32'h0000_0010, 32'h0, 0, c1);
    chk("wr_rd_value", rdata, 32'hDEAD_BEEF);

    // back-to-back reads
    do_req(2'b01, 32'h0000_0000, 32'h0, 0, c1);
    do_req(2'b01, 32'h0000_0004, 32'h0, 0, c2);
    chk("b2b_gap", c2 - c1, 4);

    // input disturbance during RD_WAIT
    do_req(2'b01, 32'h0000_0010, 32'h0, 1, c1);

    // reset in the middle of the write pulse (word 64 never read back)
    @(posedge clk); #1;
    memrw = 2'b10; memaddr = 32'h0000_0100; memdata = 32'h1234_5678;
    found = 0; k = 0;
    while (!found && k < 10) begin
      @(negedge clk); k++;
      if (sram_we_n === 1'b0) found = 1;
    end
    chk("midwr_pulse_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwr_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
    chk("midwr_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; memrw = 2'b00;
    last_rd = 32'h0;  // reset clears rdata
    do_req(2'b01, 32'h0000_0010, 32'h0, 0, c1);

`ifdef DMEM_ALIGN_CHK_EN
    do_req(2'b10, 32'h0000_0013, 32'h5555_AAAA, 0, c1);
    do_req(2'b01, 32'h0000_0011, 32'h0, 0, c1);
    do_req(2'b01, 32'h0000_0010, 32'h0, 0, c1);
    chk("mis_no_write", rdata, 32'hDEAD_BEEF);
`endif

    // randomized stream over 64 words, all four memrw codes
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rw;
      logic [31:0] a;
      rw = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 63)) << 2;
      do_req(rw, a, $urandom, 0, c1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
